// File: rtl/instruction_decode.sv
// Decode stage: register file, branch/jump resolution back to fetch,
// and the registered ID/EX bundle toward execute.
module instruction_decode #(
   parameter int NB_REG      = 32,
   parameter int NB_INSTR    = 32,
   parameter int N_REGS      = 32,
   parameter int NB_REG_ADDR = 5,
   parameter int NB_INM_I    = 16,
   parameter int NB_INM_J    = 26
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_valid,
   input  logic [NB_INSTR-1:0]    i_ir,
   input  logic [NB_REG-1:0]      i_pc,
   input  logic                   i_wb_we,
   input  logic [NB_REG_ADDR-1:0] i_wb_addr,
   input  logic [NB_REG-1:0]      i_wb_data,
   output logic                   o_branch,
   output logic                   o_jump_inm,
   output logic                   o_jump_rs,
   output logic [NB_INM_I-1:0]    o_inm_i,
   output logic [NB_INM_J-1:0]    o_inm_j,
   output logic [NB_REG-1:0]      o_rs,
   output logic                   o_nop_reg,
   output logic [NB_REG-1:0]      o_pc,
   output logic [NB_REG-1:0]      o_rs_data,
   output logic [NB_REG-1:0]      o_rt_data,
   output logic [NB_REG-1:0]      o_ext_inm,
   output logic [NB_REG_ADDR-1:0] o_rt_addr,
   output logic [NB_REG_ADDR-1:0] o_wb_addr,
   output logic                   o_reg_write,
   output logic [NB_INSTR-1:0]    o_instr
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   localparam logic [NB_REG_ADDR-1:0] RA_ADDR = NB_REG_ADDR'(31);

   logic [5:0]             opcode;
   logic [5:0]             funct;
   logic [NB_REG_ADDR-1:0] rs_addr;
   logic [NB_REG_ADDR-1:0] rt_addr;
   logic [NB_REG_ADDR-1:0] rd_addr;

   assign opcode  = i_ir[31:26];
   assign funct   = i_ir[5:0];
   assign rs_addr = i_ir[25:21];
   assign rt_addr = i_ir[20:16];
   assign rd_addr = i_ir[15:11];

   logic [NB_REG-1:0] rf [N_REGS];
   logic [NB_REG-1:0] rs_val;
   logic [NB_REG-1:0] rt_val;

   // Reads see a same-cycle writeback so no forwarding is needed upstream
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs_addr != '0)
         rs_val = (i_wb_we && i_wb_addr == rs_addr) ? i_wb_data : rf[rs_addr];
      if (rt_addr != '0)
         rt_val = (i_wb_we && i_wb_addr == rt_addr) ? i_wb_data : rf[rt_addr];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < N_REGS; i++)
            rf[i] <= '0;
      end else if (i_wb_we && i_valid && i_wb_addr != '0) begin
         rf[i_wb_addr] <= i_wb_data;
      end
   end

   logic is_jr;
   logic is_jalr;
   logic squash;

   assign is_jr   = (opcode == OP_SPECIAL) && (funct == FN_JR);
   assign is_jalr = (opcode == OP_SPECIAL) && (funct == FN_JALR);

   assign o_jump_inm = i_valid && (opcode == OP_J || opcode == OP_JAL);
   assign o_jump_rs  = i_valid && (is_jr || is_jalr);
   assign o_branch   = i_valid &&
                       ((opcode == OP_BEQ && rs_val == rt_val) ||
                        (opcode == OP_BNE && rs_val != rt_val));
   assign squash     = o_branch || o_jump_inm || o_jump_rs;

   assign o_inm_i = i_ir[NB_INM_I-1:0];
   assign o_inm_j = i_ir[NB_INM_J-1:0];
   assign o_rs    = rs_val;

   logic [NB_REG-1:0] ext_inm;
   logic              zext;

   assign zext = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                 (opcode == OP_XORI);

   always_comb begin
      ext_inm = {{(NB_REG-NB_INM_I){i_ir[NB_INM_I-1]}}, i_ir[NB_INM_I-1:0]};
      if (zext)
         ext_inm = {{(NB_REG-NB_INM_I){1'b0}}, i_ir[NB_INM_I-1:0]};
   end

   logic [NB_REG_ADDR-1:0] dst_addr;
   logic                   dst_we;

   always_comb begin
      dst_addr = '0;
      dst_we   = 1'b0;
      unique case (1'b1)
         (opcode == OP_SPECIAL): begin
            dst_addr = rd_addr;
            dst_we   = !is_jr;
         end
         (opcode == OP_JAL): begin
            dst_addr = RA_ADDR;
            dst_we   = 1'b1;
         end
         (opcode[5:3] == 3'b001 || opcode[5:3] == 3'b100): begin
            dst_addr = rt_addr;
            dst_we   = 1'b1;
         end
         default: begin
            dst_addr = '0;
            dst_we   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_nop_reg   <= 1'b0;
         o_pc        <= '0;
         o_rs_data   <= '0;
         o_rt_data   <= '0;
         o_ext_inm   <= '0;
         o_rt_addr   <= '0;
         o_wb_addr   <= '0;
         o_reg_write <= 1'b0;
         o_instr     <= '0;
      end else if (i_valid) begin
         o_nop_reg   <= squash;
         o_pc        <= i_pc;
         o_rs_data   <= rs_val;
         o_rt_data   <= rt_val;
         o_ext_inm   <= ext_inm;
         o_rt_addr   <= rt_addr;
         o_wb_addr   <= dst_addr;
         o_reg_write <= dst_we;
         o_instr     <= i_ir;
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios then random traffic,
// all checked against a register-array reference model.
module tb_instruction_decode;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic [31:0] i_ir;
   logic [31:0] i_pc;
   logic        i_wb_we;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_branch;
   logic        o_jump_inm;
   logic        o_jump_rs;
   logic [15:0] o_inm_i;
   logic [25:0] o_inm_j;
   logic [31:0] o_rs;
   logic        o_nop_reg;
   logic [31:0] o_pc;
   logic [31:0] o_rs_data;
   logic [31:0] o_rt_data;
   logic [31:0] o_ext_inm;
   logic [4:0]  o_rt_addr;
   logic [4:0]  o_wb_addr;
   logic        o_reg_write;
   logic [31:0] o_instr;

   instruction_decode dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .i_ir        (i_ir),
      .i_pc        (i_pc),
      .i_wb_we     (i_wb_we),
      .i_wb_addr   (i_wb_addr),
      .i_wb_data   (i_wb_data),
      .o_branch    (o_branch),
      .o_jump_inm  (o_jump_inm),
      .o_jump_rs   (o_jump_rs),
      .o_inm_i     (o_inm_i),
      .o_inm_j     (o_inm_j),
      .o_rs        (o_rs),
      .o_nop_reg   (o_nop_reg),
      .o_pc        (o_pc),
      .o_rs_data   (o_rs_data),
      .o_rt_data   (o_rt_data),
      .o_ext_inm   (o_ext_inm),
      .o_rt_addr   (o_rt_addr),
      .o_wb_addr   (o_wb_addr),
      .o_reg_write (o_reg_write),
      .o_instr     (o_instr)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_rf [32];
   logic [31:0] e_pc, e_rs, e_rt, e_ext, e_instr;
   logic [4:0]  e_rt_addr, e_wb_addr;
   logic        e_rw, e_nop;

   // Comb outputs observed in the most recent step
   logic [31:0] seen_rs;
   logic        seen_br, seen_ji, seen_jr;
   logic [15:0] seen_inm_i;
   logic [25:0] seen_inm_j;

   function automatic logic [31:0] m_read(input int a, input logic we,
                                          input int wa, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wa == a) return wd;
      return m_rf[a];
   endfunction

   function automatic logic [31:0] m_ext(input int op, input int imm);
      int v;
      v = imm;
      if (!(op == 12 || op == 13 || op == 14) && imm >= 32768)
         v = imm - 65536;
      return 32'(v);
   endfunction

   task automatic step(input logic rst, input logic v, input logic [31:0] ir,
                       input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
      int op, fn, rs, rt, rd;
      logic [31:0] rsv, rtv;
      logic br, ji, jr, dwe;
      int dadr;
      @(negedge i_clock);
      i_reset   = rst;
      i_valid   = v;
      i_ir      = ir;
      i_pc      = pc;
      i_wb_we   = we;
      i_wb_addr = wa;
      i_wb_data = wd;
      #1;
      op = int'(ir[31:26]);
      fn = int'(ir[5:0]);
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      rsv = m_read(rs, we, int'(wa), wd);
      rtv = m_read(rt, we, int'(wa), wd);
      ji = v && (op == 2 || op == 3);
      jr = v && op == 0 && (fn == 8 || fn == 9);
      br = v && ((op == 4 && rsv == rtv) || (op == 5 && rsv != rtv));
      seen_rs    = o_rs;
      seen_br    = o_branch;
      seen_ji    = o_jump_inm;
      seen_jr    = o_jump_rs;
      seen_inm_i = o_inm_i;
      seen_inm_j = o_inm_j;
      if (!rst) begin
         check("branch", 32'(o_branch), 32'(br));
         check("jump_inm", 32'(o_jump_inm), 32'(ji));
         check("jump_rs", 32'(o_jump_rs), 32'(jr));
         check("inm_i", 32'(o_inm_i), {16'd0, ir[15:0]});
         check("inm_j", 32'(o_inm_j), {6'd0, ir[25:0]});
         check("rs", o_rs, rsv);
      end
      if (op == 0) begin
         dadr = rd;
         dwe  = (fn != 8);
      end else if (op == 3) begin
         dadr = 31;
         dwe  = 1'b1;
      end else if (op / 8 == 1 || op / 8 == 4) begin
         dadr = rt;
         dwe  = 1'b1;
      end else begin
         dadr = 0;
         dwe  = 1'b0;
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
         {e_pc, e_rs, e_rt, e_ext, e_instr} = '0;
         {e_rt_addr, e_wb_addr, e_rw, e_nop} = '0;
      end else if (v) begin
         e_nop     = br || ji || jr;
         e_pc      = pc;
         e_rs      = rsv;
         e_rt      = rtv;
         e_ext     = m_ext(op, int'(ir[15:0]));
         e_instr   = ir;
         e_rt_addr = 5'(rt);
         e_wb_addr = 5'(dadr);
         e_rw      = dwe;
         if (we && wa != 0) m_rf[wa] = wd;
      end
      @(posedge i_clock);
      #1;
      check("nop_reg", 32'(o_nop_reg), 32'(e_nop));
      check("pc", o_pc, e_pc);
      check("rs_data", o_rs_data, e_rs);
      check("rt_data", o_rt_data, e_rt);
      check("ext_inm", o_ext_inm, e_ext);
      check("rt_addr", 32'(o_rt_addr), 32'(e_rt_addr));
      check("wb_addr", 32'(o_wb_addr), 32'(e_wb_addr));
      check("reg_write", 32'(o_reg_write), 32'(e_rw));
      check("instr", o_instr, e_instr);
   endtask

   task automatic wr(input int r, input logic [31:0] d);
      step(1'b0, 1'b1, 32'd0, 32'h100, 1'b1, 5'(r), d);
   endtask

   function automatic logic [31:0] rand_ir();
      int ops [12];
      int fns [5];
      logic [31:0] ir;
      ops = '{0, 2, 3, 4, 5, 8, 12, 13, 14, 15, 35, 43};
      fns = '{32, 8, 9, 34, 0};
      ir = $urandom;
      ir[31:26] = 6'(ops[$urandom_range(0, 11)]);
      ir[25:21] = 5'($urandom_range(0, 7));
      ir[20:16] = 5'($urandom_range(0, 7));
      if (ir[31:26] == 6'd0) ir[5:0] = 6'(fns[$urandom_range(0, 4)]);
      return ir;
   endfunction

   initial begin
      logic [31:0] ir;
      logic        rst, v, we;
      // Reset held two cycles with a live instruction present
      step(1'b1, 1'b1, 32'h2008_0005, 32'h44, 1'b1, 5'd3, 32'hAA);
      step(1'b1, 1'b1, 32'h2008_0005, 32'h48, 1'b1, 5'd3, 32'hAA);
      check("rst_nop", 32'(o_nop_reg), 32'd0);
      check("rst_instr", o_instr, 32'd0);
      for (int k = 0; k < 32; k++) begin
         step(1'b0, 1'b0, {6'd8, 5'(k), 21'd0}, 32'd0, 1'b0, 5'd0, 32'd0);
         check("rf_clear", seen_rs, 32'd0);
      end

      // Writeback bypass into add r9,r8,r8
      step(1'b0, 1'b1, 32'h0108_4820, 32'h104, 1'b1, 5'd8, 32'h1234);
      check("byp_rs", seen_rs, 32'h1234);
      check("byp_rs_data", o_rs_data, 32'h1234);
      check("byp_rt_data", o_rt_data, 32'h1234);
      check("byp_wb_addr", 32'(o_wb_addr), 32'd9);
      check("byp_reg_write", 32'(o_reg_write), 32'd1);

      // r0 stays zero
      wr(0, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 5'd0, 32'd0);
      check("r0_read", seen_rs, 32'd0);

      // BEQ taken then not taken
      wr(1, 32'd7);
      wr(2, 32'd7);
      step(1'b0, 1'b1, 32'h1022_0003, 32'h200, 1'b0, 5'd0, 32'd0);
      check("beq_taken", 32'(seen_br), 32'd1);
      check("beq_inm", 32'(seen_inm_i), 32'd3);
      check("beq_nop", 32'(o_nop_reg), 32'd1);
      wr(2, 32'd8);
      step(1'b0, 1'b1, 32'h1022_0003, 32'h208, 1'b0, 5'd0, 32'd0);
      check("beq_not", 32'(seen_br), 32'd0);
      check("beq_not_nop", 32'(o_nop_reg), 32'd0);

      // Jumps
      step(1'b0, 1'b1, 32'h0800_0100, 32'h300, 1'b0, 5'd0, 32'd0);
      check("j_flag", 32'(seen_ji), 32'd1);
      check("j_target", 32'(seen_inm_j), 32'h100);
      step(1'b0, 1'b1, 32'h0C00_0100, 32'h304, 1'b0, 5'd0, 32'd0);
      check("jal_ra", 32'(o_wb_addr), 32'd31);
      check("jal_we", 32'(o_reg_write), 32'd1);
      wr(3, 32'h40);
      step(1'b0, 1'b1, 32'h0060_0008, 32'h308, 1'b0, 5'd0, 32'd0);
      check("jr_flag", 32'(seen_jr), 32'd1);
      check("jr_rs", seen_rs, 32'h40);
      check("jr_we", 32'(o_reg_write), 32'd0);

      // Immediate extension
      step(1'b0, 1'b1, 32'h3400_8000, 32'h400, 1'b0, 5'd0, 32'd0);
      check("ori_zext", o_ext_inm, 32'h0000_8000);
      step(1'b0, 1'b1, 32'h2000_8000, 32'h404, 1'b0, 5'd0, 32'd0);
      check("addi_sext", o_ext_inm, 32'hFFFF_8000);

      // Stall with a taken branch and a writeback present
      step(1'b0, 1'b1, 32'h1021_0003, 32'h500, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b0, 32'h1021_0003, 32'h504, 1'b1, 5'd5, 32'hDEAD);
      check("stall_br", 32'(seen_br), 32'd0);
      check("stall_nop", 32'(o_nop_reg), 32'd1);
      check("stall_pc", o_pc, 32'h500);
      step(1'b0, 1'b0, {6'd8, 5'd5, 21'd0}, 32'd0, 1'b0, 5'd0, 32'd0);
      check("stall_no_wr", seen_rs, 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         ir  = rand_ir();
         rst = ($urandom_range(0, 49) == 0);
         v   = ($urandom_range(0, 4) != 0);
         we  = $urandom_range(0, 1) == 1;
         step(rst, v, ir, $urandom, we, 5'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0) ? 32'd7 : $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage directly downstream of instruction fetch.
- Consumes the fetched instruction word and its PC+4, holds the 32x32 register file, and resolves jumps and branches in this stage.
- Returns branch/jump controls, immediates, RS data and the squash flag (o_nop_reg) combinationally or one cycle later to fetch.
- Presents a registered ID/EX bundle to execute.

Parameters:
- NB_REG, 32, register/data width
- NB_INSTR, 32, instruction width
- N_REGS, 32, register file depth; index 0 is hardwired zero
- NB_REG_ADDR, 5, register index width
- NB_INM_I, 16, I-type immediate width
- NB_INM_J, 26, J-type target width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline advance enable
- i_ir  in  NB_INSTR  instruction from fetch (all zero when squashed)
- i_pc  in  NB_REG  PC+4 of i_ir from fetch
- i_wb_we  in  1  writeback write enable
- i_wb_addr  in  NB_REG_ADDR  writeback destination
- i_wb_data  in  NB_REG  writeback data
- o_branch  out  1  taken BEQ/BNE (combinational, to fetch)
- o_jump_inm  out  1  J/JAL (combinational, to fetch)
- o_jump_rs  out  1  JR/JALR (combinational, to fetch)
- o_inm_i  out  NB_INM_I  i_ir[15:0] (combinational)
- o_inm_j  out  NB_INM_J  i_ir[25:0] (combinational)
- o_rs  out  NB_REG  RS read data, bypassed (combinational)
- o_nop_reg  out  1  registered squash flag to fetch
- o_pc  out  NB_REG  registered PC+4
- o_rs_data, o_rt_data  out  NB_REG  registered operands
- o_ext_inm  out  NB_REG  registered extended immediate
- o_rt_addr  out  NB_REG_ADDR  registered i_ir[20:16]
- o_wb_addr  out  NB_REG_ADDR  registered destination register
- o_reg_write  out  1  registered write enable for this instruction
- o_instr  out  NB_INSTR  registered instruction

Behaviour:
- Reset:
  - All registered outputs go to 0, including o_nop_reg.
  - All registers r0..r31 clear to 0.
  - Reset has priority over i_valid and over any writeback.
- Register file:
  - Write at posedge when i_wb_we & i_valid & i_wb_addr!=0. Writes to r0 are ignored; r0 always reads 0.
  - Reads are combinational on rs=i_ir[25:21] and rt=i_ir[20:16].
  - Bypass: if i_wb_we and i_wb_addr equals the read index (non-zero), the read returns i_wb_data in the same cycle.
- Control decode, with opcode=i_ir[31:26] and funct=i_ir[5:0]:
  - o_jump_inm = i_valid & opcode∈{000010,000011}.
  - o_jump_rs = i_valid & opcode==0 & funct∈{001000,001001}.
  - o_branch = i_valid & ((opcode==000100 & rs==rt) | (opcode==000101 & rs!=rt)). The comparison uses bypassed data.
  - At most one of the three is ever high.
- Squash: on posedge with i_valid, o_nop_reg <= o_branch|o_jump_inm|o_jump_rs. This squashes the one wrongly fetched instruction. A zero instruction decodes as SLL r0 with no jump, so back-to-back squashes cannot chain.
- ID/EX register, loaded on posedge when i_valid & !i_reset; holds its value otherwise:
  - o_pc <= i_pc.
  - o_rs_data and o_rt_data take the bypassed reads.
  - o_instr <= i_ir; o_rt_addr <= i_ir[20:16].
  - o_ext_inm: zero-extended for opcodes 001100/001101/001110 (ANDI/ORI/XORI); sign-extended otherwise.
- Destination register (o_wb_addr / o_reg_write):
  - R-type (opcode 0): rd=i_ir[15:11], write=1, except JR (write=0).
  - JAL: 31, write=1.
  - JALR: rd, write=1.
  - I-type ALU/LUI/loads (opcode 001xxx, 100xxx): rt, write=1.
  - Stores, BEQ/BNE, J: write=0.
  - Zero instruction: write=1 to r0; this is harmless.
- Latency: controls back to fetch are 0 cycles; the ID/EX bundle is 1 cycle.
- Reset mid-operation: a pending squash is cleared, so o_nop_reg=0 after reset.

Test Plan:
- Reset: hold i_reset 2 cycles with i_ir=0x2008_0005 -> all registered outputs 0, o_nop_reg=0; r0..r31 read 0.
- Writeback bypass: i_wb_we=1, i_wb_addr=8, i_wb_data=0x1234, i_ir=0x0108_4820 (add r9,r8,r8) -> same-cycle o_rs=0x1234; next cycle o_rs_data=o_rt_data=0x1234, o_wb_addr=9, o_reg_write=1.
- r0 write: i_wb_addr=0, i_wb_data=0xFFFF_FFFF -> reads of r0 stay 0.
- BEQ taken/not taken: r1=r2=7, i_ir=0x1022_0003 -> o_branch=1, o_inm_i=3, o_nop_reg=1 next cycle. With r2=8 -> o_branch=0, o_nop_reg=0.
- Jumps:
  - J 0x0000100 (0x0800_0100) -> o_jump_inm=1, o_inm_j=0x100.
  - JAL -> o_wb_addr=31, o_reg_write=1.
  - JR r3 with r3=0x40 -> o_jump_rs=1, o_rs=0x40, o_reg_write=0.
- Immediates and stall: ORI with imm 0x8000 -> o_ext_inm=0x0000_8000; ADDI with imm 0x8000 -> 0xFFFF_8000. Drop i_valid with a taken branch present -> o_branch=0, no register-file write, ID/EX bundle and o_nop_reg unchanged.
